// File: rtl/lsu_pkg.sv
// Shared types for the data-memory load/store unit: access sizes, FSM states
// and the byte-to-word address helper.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'b00,
      SZ_HALF    = 2'b01,
      SZ_WORD    = 2'b10,
      SZ_ILLEGAL = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STORE,
      RMW_RD,
      RMW_WR,
      RESP
   } state_e;

   function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
      return {byte_addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends a load lane from a memory word and
// merges sub-word store data into the old word for read-modify-write.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int REG_SIZE = XLEN
) (
   input  logic [REG_SIZE-1:0] i_word,
   input  logic [1:0]          i_offset,
   input  size_e               i_size,
   input  logic                i_unsigned,
   input  logic [REG_SIZE-1:0] i_wdata,
   output logic [REG_SIZE-1:0] o_load_data,
   output logic [REG_SIZE-1:0] o_merged
);

   logic [REG_SIZE-1:0] w_byte_shift;
   logic [REG_SIZE-1:0] w_half_shift;
   logic [4:0]          w_byte_pos;
   logic [4:0]          w_half_pos;

   // Halves use addr[1] only; addr[0] is guaranteed clear for non-faulting halves.
   assign w_byte_pos   = {i_offset, 3'b000};
   assign w_half_pos   = {i_offset[1], 4'b0000};
   assign w_byte_shift = i_word >> w_byte_pos;
   assign w_half_shift = i_word >> w_half_pos;

   always_comb begin
      o_load_data = i_word;
      o_merged    = i_wdata;
      case (i_size)
         SZ_BYTE: begin
            o_load_data = {{(REG_SIZE-8){w_byte_shift[7] & ~i_unsigned}}, w_byte_shift[7:0]};
            o_merged    = i_word;
            o_merged[w_byte_pos +: 8] = i_wdata[7:0];
         end
         SZ_HALF: begin
            o_load_data = {{(REG_SIZE-16){w_half_shift[15] & ~i_unsigned}}, w_half_shift[15:0]};
            o_merged    = i_word;
            o_merged[w_half_pos +: 16] = i_wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Memory-stage load/store initiator: one request at a time, sub-word stores via
// read-modify-write, single-cycle response pulse with load data or fault.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int REG_SIZE       = XLEN,
   parameter int MEM_SIZE_IN_KB = 1,
   parameter int NO_OF_REGS     = MEM_SIZE_IN_KB*1024/4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [1:0]          req_size_i,
   input  logic                req_unsigned_i,
   input  logic [REG_SIZE-1:0] req_addr_i,
   input  logic [REG_SIZE-1:0] req_wdata_i,
   output logic                rsp_valid_o,
   output logic [REG_SIZE-1:0] rsp_rdata_o,
   output logic                rsp_fault_o,
   output logic                dmem_we_o,
   output logic [REG_SIZE-1:0] dmem_addr_o,
   output logic [REG_SIZE-1:0] dmem_wdata_o,
   input  logic [REG_SIZE-1:0] dmem_rdata_i
);

   localparam logic [REG_SIZE-1:0] KB_BYTES  = REG_SIZE'(MEM_SIZE_IN_KB*1024);
   localparam logic [REG_SIZE-1:0] NUM_WORDS = REG_SIZE'(NO_OF_REGS);

   state_e              r_state;
   state_e              w_state_next;
   logic                r_we;
   logic                r_unsigned;
   size_e               r_size;
   logic [REG_SIZE-1:0] r_addr;
   logic [REG_SIZE-1:0] r_wdata;
   logic [REG_SIZE-1:0] r_merged;
   logic [REG_SIZE-1:0] r_rsp_rdata;
   logic                r_rsp_fault;

   size_e               w_req_size;
   logic                w_accept;
   logic                w_misaligned;
   logic                w_out_of_range;
   logic                w_fault;
   logic [REG_SIZE-1:0] w_load_data;
   logic [REG_SIZE-1:0] w_merged;

   assign w_req_size     = size_e'(req_size_i);
   assign w_accept       = req_valid_i && req_ready_o;
   assign w_out_of_range = (req_addr_i >= KB_BYTES) ||
                           ({2'b00, req_addr_i[REG_SIZE-1:2]} >= NUM_WORDS);
   assign w_fault        = w_misaligned || w_out_of_range;

   always_comb begin
      w_misaligned = 1'b0;
      case (w_req_size)
         SZ_HALF:    w_misaligned = req_addr_i[0];
         SZ_WORD:    w_misaligned = (req_addr_i[1:0] != 2'b00);
         SZ_ILLEGAL: w_misaligned = 1'b1;
         default:    w_misaligned = 1'b0;
      endcase
   end

   lsu_align #(
      .REG_SIZE (REG_SIZE)
   ) u_align (
      .i_word      (dmem_rdata_i),
      .i_offset    (r_addr[1:0]),
      .i_size      (r_size),
      .i_unsigned  (r_unsigned),
      .i_wdata     (r_wdata),
      .o_load_data (w_load_data),
      .o_merged    (w_merged)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Every output is forced low while reset is high so an interrupted RMW never writes.
   always_comb begin
      w_state_next = r_state;
      req_ready_o  = 1'b0;
      rsp_valid_o  = 1'b0;
      dmem_we_o    = 1'b0;
      dmem_addr_o  = '0;
      dmem_wdata_o = '0;
      if (!rst_i) begin
         if (r_state != IDLE) begin
            dmem_addr_o = word_addr(r_addr);
         end
         case (r_state)
            IDLE: begin
               req_ready_o = 1'b1;
               if (req_valid_i) begin
                  if (w_fault)                 w_state_next = RESP;
                  else if (!req_we_i)          w_state_next = LOAD;
                  else if (w_req_size == SZ_WORD) w_state_next = STORE;
                  else                         w_state_next = RMW_RD;
               end
            end
            LOAD:   w_state_next = RESP;
            STORE: begin
               dmem_we_o    = 1'b1;
               dmem_wdata_o = r_wdata;
               w_state_next = RESP;
            end
            RMW_RD: w_state_next = RMW_WR;
            RMW_WR: begin
               dmem_we_o    = 1'b1;
               dmem_wdata_o = r_merged;
               w_state_next = RESP;
            end
            RESP: begin
               rsp_valid_o  = 1'b1;
               w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_we        <= 1'b0;
         r_unsigned  <= 1'b0;
         r_size      <= SZ_BYTE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_merged    <= '0;
         r_rsp_rdata <= '0;
         r_rsp_fault <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we        <= req_we_i;
            r_unsigned  <= req_unsigned_i;
            r_size      <= w_req_size;
            r_addr      <= req_addr_i;
            r_wdata     <= req_wdata_i;
            r_rsp_rdata <= '0;
            r_rsp_fault <= w_fault;
         end
         if (r_state == LOAD) begin
            r_rsp_rdata <= w_load_data;
         end
         if (r_state == RMW_RD) begin
            r_merged <= w_merged;
         end
      end
   end

   assign rsp_rdata_o = rst_i ? '0 : r_rsp_rdata;
   assign rsp_fault_o = rst_i ? 1'b0 : r_rsp_fault;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios plus random traffic checked against a
// byte-array reference memory.
module tb_dmem_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_fault_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   logic        mem_init;
   logic [31:0] mem [256];
   logic [7:0]  ref_b [1024];

   always #5 clk_i = ~clk_i;

   dmem_lsu #(
      .REG_SIZE       (32),
      .MEM_SIZE_IN_KB (1),
      .NO_OF_REGS     (256)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid_i),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we_i),
      .req_size_i     (req_size_i),
      .req_unsigned_i (req_unsigned_i),
      .req_addr_i     (req_addr_i),
      .req_wdata_i    (req_wdata_i),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_rdata_o    (rsp_rdata_o),
      .rsp_fault_o    (rsp_fault_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_rdata_i   (dmem_rdata_i)
   );

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   // data_mem: combinational read, write on rising edge
   assign dmem_rdata_i = mem[dmem_addr_o[9:2]];
   always @(posedge clk_i) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (dmem_we_o) begin
         mem[dmem_addr_o[9:2]] <= dmem_wdata_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:2], 2'b00};
      return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
   endfunction

   // Reference: fault rules, little-endian byte memory, extension by arithmetic.
   task automatic ref_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic fault, output logic [31:0] rdata);
      int n;
      logic [63:0] v;
      fault = (sz == 2'd3) || (sz == 2'd1 && addr[0]) ||
              (sz == 2'd2 && addr[1:0] != 2'b00) || (addr >= 32'd1024);
      rdata = 32'h0;
      if (!fault) begin
         n = 1 << sz;
         if (we) begin
            for (int i = 0; i < n; i++) ref_b[addr + 32'(i)] = 8'(wd >> (8*i));
         end else begin
            v = 64'h0;
            for (int i = 0; i < n; i++) v = v | (64'(ref_b[addr + 32'(i)]) << (8*i));
            if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
            rdata = v[31:0];
         end
      end
   endtask

   // Issue one request from idle and check the whole transaction; returns load data.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got_rdata);
      logic        exp_fault, got_fault, accepted, seen;
      logic [31:0] exp_rdata, we_addr, we_data;
      int          exp_lat, lat, we_cnt, busy_ready;
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = sz;
      req_unsigned_i = uns;
      req_addr_i     = addr;
      req_wdata_i    = wd;
      accepted = 1'b0;
      for (int i = 0; i < 8 && !accepted; i++) begin
         if (req_ready_o) accepted = 1'b1;
         @(posedge clk_i); #1;
      end
      req_valid_i = 1'b0;
      check("accept", 32'(accepted), 32'd1);
      ref_req(we, sz, uns, addr, wd, exp_fault, exp_rdata);
      exp_lat = exp_fault ? 1 : ((!we || sz == 2'd2) ? 2 : 3);
      seen = 1'b0; lat = 0; we_cnt = 0; busy_ready = 0;
      got_rdata = 32'h0; got_fault = 1'b0; we_addr = 32'h0; we_data = 32'h0;
      for (int c = 1; c <= 6 && !seen; c++) begin
         if (dmem_we_o) begin
            we_cnt++;
            we_addr = dmem_addr_o;
            we_data = dmem_wdata_o;
         end
         if (req_ready_o) busy_ready++;
         if (rsp_valid_o) begin
            seen = 1'b1; lat = c;
            got_rdata = rsp_rdata_o;
            got_fault = rsp_fault_o;
         end
         @(posedge clk_i); #1;
      end
      check("rsp_seen", 32'(seen), 32'd1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("fault", 32'(got_fault), 32'(exp_fault));
      check("rdata", got_rdata, exp_rdata);
      check("we_pulses", 32'(we_cnt), (we && !exp_fault) ? 32'd1 : 32'd0);
      check("busy_ready", 32'(busy_ready), 32'd0);
      check("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
      check("ready_after", 32'(req_ready_o), 32'd1);
      if (we && !exp_fault) begin
         check("we_addr", we_addr, {addr[31:2], 2'b00});
         check("mem_word", mem[addr[9:2]], ref_word(addr));
         if (sz == 2'd2) check("we_data", we_data, wd);
      end
      n_txn++;
      $display("txn %0d we=%0d sz=%0d uns=%0d addr=%h wd=%h lat=%0d fault=%0d rdata=%h",
               n_txn, we, sz, uns, addr, wd, lat, got_fault, got_rdata);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, pre, a;
      logic [31:0] vals [3];
      int acc_cyc [3];
      int cyc, rsp_cnt;
      logic        we;
      logic [1:0]  sz;
      logic        ok;

      for (int i = 0; i < 256; i++) begin
         pre = init_word(i);
         for (int j = 0; j < 4; j++) ref_b[4*i + j] = pre[8*j +: 8];
      end

      rst_i = 1'b1; mem_init = 1'b1;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
      req_unsigned_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ready", 32'(req_ready_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_we", 32'(dmem_we_o), 32'd0);
      check("rst_addr", dmem_addr_o, 32'h0);
      check("rst_wdata", dmem_wdata_o, 32'h0);
      check("rst_rdata", rsp_rdata_o, 32'h0);
      check("rst_fault", 32'(rsp_fault_o), 32'd0);
      rst_i = 1'b0; mem_init = 1'b0;
      #1;
      check("ready_post_rst", 32'(req_ready_o), 32'd1);
      check("idle_addr", dmem_addr_o, 32'h0);

      // word store then load
      do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF, rd);
      do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd);
      check("lw_8", rd, 32'hDEAD_BEEF);

      // signed/unsigned sub-word loads
      do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h80FF_7F01, rd);
      do_req(1'b0, 2'd0, 1'b0, 32'h6, 32'h0, rd);
      check("lb_6", rd, 32'hFFFF_FFFF);
      do_req(1'b0, 2'd0, 1'b1, 32'h6, 32'h0, rd);
      check("lbu_6", rd, 32'h0000_00FF);
      do_req(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, rd);
      check("lb_7", rd, 32'hFFFF_FF80);
      do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, rd);
      check("lhu_6", rd, 32'h0000_80FF);

      // byte read-modify-write
      do_req(1'b1, 2'd2, 1'b0, 32'hC, 32'h1122_3344, rd);
      do_req(1'b1, 2'd0, 1'b0, 32'hD, 32'h0000_00AA, rd);
      check("sb_rmw_word", mem[3], 32'h1122_AA44);

      // faults
      do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, rd);
      do_req(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, rd);
      do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, rd);
      do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h1234_5678, rd);
      do_req(1'b1, 2'd0, 1'b0, 32'hFFFF_FFFD, 32'h55, rd);

      // reset during the write cycle of a half-word RMW
      pre = mem[4];
      req_we_i = 1'b1; req_size_i = 2'd1; req_unsigned_i = 1'b0;
      req_addr_i = 32'h10; req_wdata_i = 32'h0000_BEEF; req_valid_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         if (req_ready_o) ok = 1'b1;
         @(posedge clk_i); #1;
      end
      req_valid_i = 1'b0;
      check("rmw_rst_accept", 32'(ok), 32'd1);
      check("rmw_rd_no_we", 32'(dmem_we_o), 32'd0);
      @(posedge clk_i); #1;
      check("rmw_wr_we", 32'(dmem_we_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("rmw_rst_we_gated", 32'(dmem_we_o), 32'd0);
      check("rmw_rst_ready", 32'(req_ready_o), 32'd0);
      check("rmw_rst_rsp", 32'(rsp_valid_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      check("rmw_rst_ready_after", 32'(req_ready_o), 32'd1);
      rsp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); #1;
         if (rsp_valid_o) rsp_cnt++;
      end
      check("rmw_rst_no_rsp", 32'(rsp_cnt), 32'd0);
      check("rmw_rst_mem", mem[4], pre);
      check("rmw_rst_mem_ref", mem[4], ref_word(32'h10));

      // back-to-back word stores with valid held high
      vals[0] = 32'd5; vals[1] = 32'd10; vals[2] = 32'd12;
      cyc = 0;
      req_we_i = 1'b1; req_size_i = 2'd2; req_unsigned_i = 1'b0; req_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_addr_i  = 32'(4*k);
         req_wdata_i = vals[k];
         ok = 1'b0;
         acc_cyc[k] = -100;
         for (int i = 0; i < 8 && !ok; i++) begin
            if (req_ready_o) begin
               ok = 1'b1;
               acc_cyc[k] = cyc;
            end
            @(posedge clk_i); #1;
            cyc++;
         end
         check("b2b_accept", 32'(ok), 32'd1);
         ref_req(1'b1, 2'd2, 1'b0, 32'(4*k), vals[k], ok, rd);
      end
      req_valid_i = 1'b0;
      check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(posedge clk_i); #1;
         if (req_ready_o) ok = 1'b1;
      end
      check("b2b_drain", 32'(ok), 32'd1);
      for (int k = 0; k < 3; k++) begin
         do_req(1'b0, 2'd2, 1'b0, 32'(4*k), 32'h0, rd);
         check("b2b_readback", rd, vals[k]);
      end

      // random traffic against the byte-level reference
      for (int t = 0; t < 150; t++) begin
         we = 1'($urandom_range(0, 1));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 15) == 0) begin
            a = 32'h400 + 32'($urandom_range(0, 4095));
         end else begin
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
         end
         do_req(we, sz, 1'($urandom_range(0, 1)), a, $urandom, rd);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
